pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised pipeline-stage buffer for the RISC-V core. It replaces fixed, always-advancing stage flip-flop banks, such as the Decode/Execute to Memory/Writeback boundary. A 2-entry skid buffer with valid/ready handshake carries a data payload (PC, ALU result, operands, instruction) and a control field (rfwrite, wdata_sel, csr_rd/wr, is_mret). It adds stall and flush handling, bubble insertion and a stall counter, none of which the plain stage registers provide.

## Interface
Parameters:
- DATA_W, 160: payload width (PC, Alu_result, rdata1, rdata2, Instruction).
- CTRL_W, 6: control-field width. Forced to zero on bubble and flush.
- BUBBLE_DATA, 160'h0000_0013 in the low instruction slot, rest 0: payload presented when no entry is valid (instruction = NOP).
- CNT_W, 16: stall-counter width.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: upstream entry valid.
- in_ready, output, 1: buffer can accept. Equals !S_valid && !flush.
- in_data, input, DATA_W: upstream payload.
- in_ctrl, input, CTRL_W: upstream control.
- out_valid, output, 1: main entry valid.
- out_ready, input, 1: downstream accepts.
- out_data, output, DATA_W: main payload, or BUBBLE_DATA when !out_valid.
- out_ctrl, output, CTRL_W: main control, or 0 when !out_valid.
- flush, input, 1: synchronous kill of all held entries.
- occupancy, output, 2: M_valid + S_valid (0..2).
- stall_cnt, output, CNT_W: cycles with out_valid && !out_ready; saturating.

## Operation
- **Storage.** Main entry M drives the outputs. Skid entry S holds one extra item. Invariant: S_valid implies M_valid.
- **Handshakes.** acc = in_valid && in_ready. fire = out_valid && out_ready.
- **State transitions** (per cycle, flush low):
  - EMPTY (M=0, S=0): acc loads M. Next state ONE.
  - ONE, fire && acc: M reloads from input. Stay ONE.
  - ONE, fire && !acc: M_valid clears. Next state EMPTY.
  - ONE, !fire && acc: S loads from input. Next state FULL.
  - ONE, !fire && !acc: hold.
  - FULL (M=1, S=1): in_ready=0, so no acc. fire moves S into M and clears S_valid (next state ONE). !fire holds.
- **Ordering.** Entries leave in arrival order. No entry is dropped or duplicated.
- **Stability.** While out_valid && !out_ready, out_data and out_ctrl are held bit-stable.
- **Flush.**
  - On the next edge, M_valid and S_valid clear.
  - in_ready is 0 during the flush cycle, so nothing is accepted.
  - A fire in the flush cycle counts as delivered. Downstream owns that item.
- **Gating.** out_ctrl is AND-gated with out_valid. out_data is muxed to BUBBLE_DATA when !out_valid. A bubble therefore never writes the RF or CSRs and never triggers mret.
- **Stall counter.**
  - Increments each cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset, not by flush.
- **Payload registers.** These are enable-loaded only; valid bits control visibility. They reset to BUBBLE_DATA and 0.

## Timing
- **Reset** (asynchronous assert, synchronous to clk on release). While reset=0 and after release until the first acc:
  - out_valid=0, out_data=BUBBLE_DATA, out_ctrl=0.
  - in_ready=1 (when flush=0).
  - occupancy=0, stall_cnt=0.
- **Reset mid-operation.** Both entries are lost immediately, with no edge required.
- **Latency.** An item accepted at edge N is visible on out_* after edge N, in cycle N+1.
- **Throughput.** 1 item/cycle when out_ready is held high.
- **Full-buffer rate.** in_ready is registered state gated only by flush, with no combinational path from out_ready. After a full stall, refill resumes at 1/cycle one cycle after the first fire.
- **Simultaneous flush and in_valid.** The input is dropped and upstream sees in_ready=0.
- **Simultaneous flush and fire.** The item is delivered and the buffer is empty next cycle.
- **Counter wrap.** None; it saturates.

## Test plan
1. **Reset and idle.** Assert reset=0 mid-stream with 2 entries held → out_valid=0 and out_ctrl=0 immediately; out_data=…0013; occupancy=0; in_ready=1 after release.
2. **Streaming.** in_valid=1, out_ready=1, payloads 1..8 on consecutive cycles → out_data 1..8 on consecutive cycles, one cycle later; occupancy stays 1; stall_cnt=0.
3. **Backpressure.** Send 3 items with out_ready=0 → items 1 and 2 accepted; in_ready=0 on the third; occupancy=2; out_data held at 1; stall_cnt increments each cycle. Release out_ready → order 1,2,3, with no loss.
4. **Flush.** Hold 2 entries with ctrl=6'h3F, then pulse flush with in_valid=1 → next cycle out_valid=0, out_ctrl=0, occupancy=0; flushed input never appears.
5. **Flush with fire.** occupancy=1, out_ready=1, flush=1 → item consumed that cycle; next cycle empty; no duplicate.
6. **Saturation** (CNT_W=4). Stall for 20 cycles → stall_cnt stops at 15; a later flush does not clear it.

Source files
------------

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready handshake bundle carrying one pipeline-stage payload and its control field.
// The master drives valid/data/ctrl and the slave returns ready.
interface pipe_stage_buf_if #(
  parameter int unsigned DATA_W = 160,
  parameter int unsigned CTRL_W = 6
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (
    output valid,
    output data,
    output ctrl,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  ctrl,
    output ready
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer between pipeline stages with flush, bubble gating and a
// saturating stall counter. Main entry M drives the outputs and skid entry S backs it up.
module pipe_stage_buf #(
  parameter int unsigned       DATA_W      = 160,
  parameter int unsigned       CTRL_W      = 6,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(32'h0000_0013),
  parameter int unsigned       CNT_W       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  pipe_stage_buf_if.slave      in_if,
  pipe_stage_buf_if.master     out_if,
  input  logic                 flush_i,
  output logic [1:0]           occupancy_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  localparam logic [1:0] StEmpty = 2'b00;
  localparam logic [1:0] StOne   = 2'b10;
  localparam logic [1:0] StFull  = 2'b11;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic              m_valid_q, m_valid_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              m_load, s_load;
  logic              in_ready, acc, fire;

  // in_ready depends only on registered state and flush, so a stall never
  // chains combinationally from downstream ready to upstream ready.
  assign in_ready = !s_valid_q && !flush_i;
  assign acc      = in_if.valid && in_ready;
  assign fire     = m_valid_q && out_if.ready;

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_load    = 1'b0;
    s_load    = 1'b0;
    m_data_d  = in_if.data;
    m_ctrl_d  = in_if.ctrl;
    case ({m_valid_q, s_valid_q})
      StOne: begin
        if (fire) begin
          m_load    = acc;
          m_valid_d = acc;
        end else if (acc) begin
          s_load    = 1'b1;
          s_valid_d = 1'b1;
        end
      end
      StFull: begin
        if (fire) begin
          m_load    = 1'b1;
          m_data_d  = s_data_q;
          m_ctrl_d  = s_ctrl_q;
          s_valid_d = 1'b0;
        end
      end
      default: begin
        // Empty, and the unreachable S-without-M encoding, both restart cleanly.
        s_valid_d = 1'b0;
        m_load    = acc;
        m_valid_d = acc;
      end
    endcase
    if (flush_i) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid_q && !out_if.ready && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_valid_q   <= 1'b0;
      s_valid_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      s_valid_q   <= s_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Payload registers are enable-loaded only; the valid bits decide visibility.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_data_q <= BUBBLE_DATA;
      m_ctrl_q <= '0;
      s_data_q <= BUBBLE_DATA;
      s_ctrl_q <= '0;
    end else begin
      if (m_load) begin
        m_data_q <= m_data_d;
        m_ctrl_q <= m_ctrl_d;
      end
      if (s_load) begin
        s_data_q <= in_if.data;
        s_ctrl_q <= in_if.ctrl;
      end
    end
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = m_valid_q;
  assign out_if.data  = m_valid_q ? m_data_q : BUBBLE_DATA;
  assign out_if.ctrl  = m_ctrl_q & {CTRL_W{m_valid_q}};
  assign occupancy_o  = {1'b0, m_valid_q} + {1'b0, s_valid_q};
  assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: streaming, backpressure, flush, flush-with-fire,
// counter saturation and asynchronous reset with entries held.
module tb_pipe_stage_buf;
  localparam int unsigned DW = 160;
  localparam int unsigned CW = 6;
  localparam int unsigned NW = 4;
  localparam logic [DW-1:0] Bubble = DW'(32'h0000_0013);

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt;
  int            checks;
  int            errors;

  pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) up_if ();
  pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) dn_if ();

  pipe_stage_buf #(
    .DATA_W     (DW),
    .CTRL_W     (CW),
    .BUBBLE_DATA(Bubble),
    .CNT_W      (NW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_if      (up_if),
    .out_if     (dn_if),
    .flush_i    (flush),
    .occupancy_o(occupancy),
    .stall_cnt_o(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    flush        = 1'b0;
    up_if.valid  = 1'b0;
    up_if.data   = '0;
    up_if.ctrl   = '0;
    dn_if.ready  = 1'b0;
    #12;
    check("rst_out_valid", DW'(dn_if.valid), DW'(0));
    check("rst_out_data", dn_if.data, Bubble);
    check("rst_out_ctrl", DW'(dn_if.ctrl), DW'(0));
    check("rst_occupancy", DW'(occupancy), DW'(0));
    check("rst_in_ready", DW'(up_if.ready), DW'(1));
    check("rst_stall_cnt", DW'(stall_cnt), DW'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming: items 1..8 back to back, each visible right after its accept edge.
    dn_if.ready = 1'b1;
    up_if.valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      up_if.data = DW'(i);
      up_if.ctrl = CW'(i);
      step();
      check($sformatf("stream_data_%0d", i), dn_if.data, DW'(i));
      check($sformatf("stream_occ_%0d", i), DW'(occupancy), DW'(1));
    end
    check("stream_ctrl_last", DW'(dn_if.ctrl), DW'(8));
    up_if.valid = 1'b0;
    step();
    check("stream_drain_occ", DW'(occupancy), DW'(0));
    check("stream_stall_cnt", DW'(stall_cnt), DW'(0));

    // Backpressure: two accepted, third refused, then released in order.
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = DW'(101);
    up_if.ctrl  = CW'(1);
    step();
    up_if.data = DW'(102);
    up_if.ctrl = CW'(2);
    step();
    up_if.data = DW'(103);
    up_if.ctrl = CW'(3);
    check("bp_occ_full", DW'(occupancy), DW'(2));
    check("bp_in_ready_full", DW'(up_if.ready), DW'(0));
    check("bp_stall_1", DW'(stall_cnt), DW'(1));
    step();
    check("bp_data_held", dn_if.data, DW'(101));
    check("bp_stall_2", DW'(stall_cnt), DW'(2));
    step();
    check("bp_stall_3", DW'(stall_cnt), DW'(3));
    dn_if.ready = 1'b1;
    step();
    check("bp_second_out", dn_if.data, DW'(102));
    check("bp_occ_one", DW'(occupancy), DW'(1));
    check("bp_in_ready_back", DW'(up_if.ready), DW'(1));
    step();
    check("bp_third_out", dn_if.data, DW'(103));
    check("bp_third_ctrl", DW'(dn_if.ctrl), DW'(3));
    up_if.valid = 1'b0;
    step();
    check("bp_empty", DW'(occupancy), DW'(0));
    check("bp_stall_kept", DW'(stall_cnt), DW'(3));

    // Flush with two entries held and an input offered in the flush cycle.
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = DW'(201);
    up_if.ctrl  = 6'h3F;
    step();
    up_if.data = DW'(202);
    step();
    check("fl_ctrl_before", DW'(dn_if.ctrl), DW'(6'h3F));
    check("fl_occ_before", DW'(occupancy), DW'(2));
    check("fl_stall_4", DW'(stall_cnt), DW'(4));
    flush      = 1'b1;
    up_if.data = DW'(203);
    #1;
    check("fl_in_ready", DW'(up_if.ready), DW'(0));
    step();
    check("fl_out_valid", DW'(dn_if.valid), DW'(0));
    check("fl_out_ctrl", DW'(dn_if.ctrl), DW'(0));
    check("fl_out_data", dn_if.data, Bubble);
    check("fl_occ", DW'(occupancy), DW'(0));
    flush       = 1'b0;
    up_if.valid = 1'b0;
    step();
    check("fl_no_ghost", DW'(dn_if.valid), DW'(0));
    check("fl_stall_5", DW'(stall_cnt), DW'(5));

    // Flush together with a fire: item delivered, buffer empty afterwards.
    dn_if.ready = 1'b1;
    up_if.valid = 1'b1;
    up_if.data  = DW'(301);
    up_if.ctrl  = CW'(5);
    step();
    up_if.valid = 1'b0;
    check("ff_data", dn_if.data, DW'(301));
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("ff_occ", DW'(occupancy), DW'(0));
    check("ff_valid", DW'(dn_if.valid), DW'(0));
    step();
    check("ff_no_dup", DW'(dn_if.valid), DW'(0));

    // Saturation: long stall pins the 4-bit counter at 15; flush leaves it alone.
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = DW'(401);
    step();
    up_if.valid = 1'b0;
    repeat (20) step();
    check("sat_cnt", DW'(stall_cnt), DW'(15));
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    check("sat_after_flush", DW'(stall_cnt), DW'(15));
    check("sat_occ", DW'(occupancy), DW'(0));

    // Asynchronous reset with two entries held.
    up_if.valid = 1'b1;
    up_if.data  = DW'(501);
    up_if.ctrl  = CW'(7);
    step();
    up_if.data = DW'(502);
    step();
    up_if.valid = 1'b0;
    check("ar_occ_before", DW'(occupancy), DW'(2));
    rst_n = 1'b0;
    #1;
    check("ar_valid", DW'(dn_if.valid), DW'(0));
    check("ar_ctrl", DW'(dn_if.ctrl), DW'(0));
    check("ar_data", dn_if.data, Bubble);
    check("ar_occ", DW'(occupancy), DW'(0));
    check("ar_stall", DW'(stall_cnt), DW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("ar_in_ready", DW'(up_if.ready), DW'(1));
    check("ar_idle_valid", DW'(dn_if.valid), DW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
